matb_loader: RTL and testbench

Upstream sequencer for the B-operand path of the matrix-multiply unit. It accepts a DEPTH×DEPTH B matrix as a row-major valid/ready stream and drives the B memory's write port (WrEn, row, col, data). It then drives the memory's shift enable (en) for exactly enough cycles to push every staggered column into the systolic array, and signals completion. One instance sits directly in front of each B memory.

---
 rtl/matb_loader.sv | 147 ++++++++++++++
 tb/tb_matb_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/matb_loader.sv
// rtl/matb_loader.sv - B-operand loader: row-major stream to B memory writes, then staggered shift enable.
// Optional build macro MATB_LOADER_TRANSPOSE_EN swaps row/col so the memory receives the transpose.
module matb_loader #(
  parameter int BITS_AB = 8,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITS_AB-1:0]  in_data,
  output logic                       WrEn,
  output logic [$clog2(DEPTH)-1:0]   row,
  output logic [$clog2(DEPTH)-1:0]   col,
  output logic signed [BITS_AB-1:0]  Bin,
  output logic                       en,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(2 * DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [SW-1:0] SHIFT_END = SW'(2 * DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [AW-1:0]              r_q, r_d, c_q, c_d;
  logic [SW-1:0]              sc_q, sc_d;
  logic                       wren_q, wren_d;
  logic                       en_q, en_d;
  logic [AW-1:0]              row_q, row_d, col_q, col_d;
  logic signed [BITS_AB-1:0]  bin_q, bin_d;

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign WrEn     = wren_q;
  assign en       = en_q;
  assign row      = row_q;
  assign col      = col_q;
  assign Bin      = bin_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    sc_d    = sc_q;
    wren_d  = 1'b0;
    en_d    = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
    bin_d   = bin_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          wren_d = 1'b1;
          bin_d  = in_data;
`ifdef MATB_LOADER_TRANSPOSE_EN
          row_d  = c_q;
          col_d  = r_q;
`else
          row_d  = r_q;
          col_d  = c_q;
`endif
          if (c_q == LAST_IDX) begin
            c_d = '0;
            r_d = r_q + 1'b1;
            if (r_q == LAST_IDX) state_d = S_FLUSH;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_STREAM;
        en_d    = 1'b1;
        sc_d    = '0;
      end
      S_STREAM: begin
        // en_q was raised on entry, so the terminal cycle still shows en high.
        if (sc_q == SHIFT_END) begin
          state_d = S_DONE;
        end else begin
          sc_d = sc_q + 1'b1;
          en_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      wren_d  = 1'b0;
      en_d    = 1'b0;
      r_d     = '0;
      c_d     = '0;
      sc_d    = '0;
      row_d   = row_q;
      col_d   = col_q;
      bin_d   = bin_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      sc_q    <= '0;
      wren_q  <= 1'b0;
      en_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      sc_q    <= sc_d;
      wren_q  <= wren_d;
      en_q    <= en_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bin_q   <= bin_d;
    end
  end

endmodule

// File: tb/tb_matb_loader.sv
// tb/tb_matb_loader.sv - scoreboard bench for matb_loader at DEPTH=4.
module tb_matb_loader;
  localparam int D = 4;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst_n, start, abort, in_valid;
  logic                in_ready, WrEn, en, busy, done;
  logic signed [W-1:0] in_data, Bin;
  logic [1:0]          row, col;

  matb_loader #(.BITS_AB(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .WrEn(WrEn), .row(row), .col(col), .Bin(Bin),
    .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int r; int k; int d; } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int en_lo = 0, en_hi = -1, done_exp = -1, done_seen = -1, en_count = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pops expected writes and checks en/done windows set by the stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (WrEn) begin
        chk("wr_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("wr_cycle", cyc, e.c);
          chk("wr_row", int'(row), e.r);
          chk("wr_col", int'(col), e.k);
          chk("wr_data", int'(Bin), e.d);
        end
      end
      if (en || (cyc >= en_lo && cyc <= en_hi))
        chk("en", int'(en), int'(cyc >= en_lo && cyc <= en_hi));
      if (en) en_count = en_count + 1;
      if (WrEn || en) chk("wren_en_overlap", int'(WrEn & en), 0);
      if (done || cyc == done_exp) chk("done", int'(done), int'(cyc == done_exp));
      if (done) done_seen = cyc;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_start(output int st);
    start = 1'b1;
    st = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic load(input int n, input bit gaps, output int last);
    exp_t e;
    last = -1;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = W'(i + 1);
      e.c = cyc + 1;
`ifdef MATB_LOADER_TRANSPOSE_EN
      e.r = i % D;
      e.k = i / D;
`else
      e.r = i / D;
      e.k = i % D;
`endif
      e.d = i + 1;
      q.push_back(e);
      last = cyc;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_stream(input int last);
    en_lo     = last + 2;
    en_hi     = last + 2 * D;
    done_exp  = last + 2 * D + 1;
  endtask

  task automatic clear_windows();
    en_lo = 0; en_hi = -1; done_exp = -1; done_seen = -1; en_count = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_WrEn"}, int'(WrEn), 0);
    chk({tag, "_en"}, int'(en), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_Bin"}, int'(Bin), 0);
  endtask

  int st, last;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();

    // Basic back-to-back load
    clear_windows();
    do_start(st);
    @(negedge clk);
    chk("in_ready_after_start", int'(in_ready), 1);
    load(D * D, 1'b0, last);
    expect_stream(last);
    goto_cyc(last + 2 * D + 2);
    @(negedge clk);
    chk("basic_idle_busy", int'(busy), 0);
    chk("basic_start_to_done", done_seen - st, D * D + 2 * D + 1);
    chk("basic_en_count", en_count, 2 * D - 1);
    chk("basic_q_empty", q.size(), 0);
    step();

    // Gapped load with start issued during STREAM
    clear_windows();
    do_start(st);
    load(D * D, 1'b1, last);
    expect_stream(last);
    goto_cyc(last + 4);
    start = 1'b1;
    step();
    start = 1'b0;
    goto_cyc(last + 2 * D + 2);
    @(negedge clk);
    chk("gap_idle_busy", int'(busy), 0);
    chk("gap_en_count", en_count, 2 * D - 1);
    chk("gap_done_seen", done_seen, last + 2 * D + 1);
    chk("gap_q_empty", q.size(), 0);
    step();

    // Abort after five elements, with a sixth offered in the abort cycle
    clear_windows();
    do_start(st);
    load(5, 1'b0, last);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'sd6;
    step();
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    repeat (12) step();
    chk("abort_no_done", done_seen, -1);
    chk("abort_q_empty", q.size(), 0);
    do_start(st);
    load(D * D, 1'b0, last);
    expect_stream(last);
    goto_cyc(last + 2 * D + 2);
    @(negedge clk);
    chk("reload_idle_busy", int'(busy), 0);
    chk("reload_q_empty", q.size(), 0);
    step();

    // Reset during the third en cycle
    clear_windows();
    do_start(st);
    load(D * D, 1'b0, last);
    en_lo = last + 2; en_hi = last + 3;
    goto_cyc(last + 4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    repeat (15) step();
    chk("midrst_no_done", done_seen, -1);
    chk("midrst_q_empty", q.size(), 0);

    // start and abort together in IDLE
    clear_windows();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", int'(busy), 0);
    step();

    // in_valid while IDLE must not be consumed
    in_valid = 1'b1; in_data = 8'sd99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 0);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("idle_q_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
